// File: rtl/syncsearch_ctrl.sv
`timescale 1ns/1ps
// syncsearch_ctrl: receive sync-word search sequencer.
// Waits for the rx sync shift register to refill after a start request, then
// opens the correlation window and compares the register against the
// reference word once per microsecond (Hamming distance vs threshold).
// Reports a hit (timestamp + error count) or a window timeout.
module syncsearch_ctrl #(
  parameter int FILL_BITS = 64,
  parameter int TMR_W     = 16
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             p_1us,
  input  logic             search_start,
  input  logic             search_abort,
  input  logic [5:0]       regi_correthreshold,
  input  logic [TMR_W-1:0] regi_searchwindow,
  input  logic [63:0]      syncinword,
  input  logic [63:0]      ref_sync,
  output logic             correWindow,
  output logic             search_busy,
  output logic             sync_found_p,
  output logic             sync_timeout_p,
  output logic [6:0]       sync_errcnt,
  output logic [TMR_W-1:0] sync_time_us
);

  localparam int             FW        = $clog2(FILL_BITS + 1);
  localparam logic [FW-1:0]  FILL_LAST = FW'(FILL_BITS - 1);

  typedef enum logic [1:0] {IDLE, FILL, SEARCH} state_t;

  // Configuration captured at an accepted start; later register writes
  // do not disturb a search in progress.
  typedef struct packed {
    logic [5:0]       thr;
    logic [TMR_W-1:0] win;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic [FW-1:0]    fill_cnt;
  logic [TMR_W-1:0] timer;
  logic             p_eval;
  logic [63:0]      diff;
  logic [6:0]       errcnt;

  assign diff = syncinword ^ ref_sync;

  // Evaluation strobe one cycle after the tick, so the shift register has
  // already taken its new bit when we correlate.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) p_eval <= 1'b0;
    else       p_eval <= p_1us;
  end

  // Hamming distance between the received window and the reference word.
  always_comb begin
    errcnt = '0;
    for (int i = 0; i < 64; i++) errcnt = errcnt + 7'(diff[i]);
  end

  // Search sequencer with registered status and result outputs.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state          <= IDLE;
      cfg            <= '0;
      fill_cnt       <= '0;
      timer          <= '0;
      correWindow    <= 1'b0;
      search_busy    <= 1'b0;
      sync_found_p   <= 1'b0;
      sync_timeout_p <= 1'b0;
      sync_errcnt    <= '0;
      sync_time_us   <= '0;
    end else begin
      sync_found_p   <= 1'b0;
      sync_timeout_p <= 1'b0;
      if (search_abort) begin
        // Abort beats everything, including a same-cycle start or hit;
        // held results are left untouched.
        state       <= IDLE;
        correWindow <= 1'b0;
        search_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (search_start) begin
              state        <= FILL;
              search_busy  <= 1'b1;
              cfg.thr      <= regi_correthreshold;
              cfg.win      <= regi_searchwindow;
              fill_cnt     <= '0;
              timer        <= '0;
              sync_errcnt  <= '0;
              sync_time_us <= '0;
            end
          end
          FILL: begin
            // The register is fully refreshed on the FILL_BITS-th tick; its
            // delayed strobe becomes the first evaluation in SEARCH.
            if (p_1us) begin
              if (fill_cnt == FILL_LAST) begin
                state       <= SEARCH;
                correWindow <= 1'b1;
                timer       <= '0;
              end else begin
                fill_cnt <= fill_cnt + FW'(1);
              end
            end
          end
          SEARCH: begin
            if (p_eval) begin
              if (errcnt <= {1'b0, cfg.thr}) begin
                // Hit takes precedence over a coincident window expiry.
                sync_found_p <= 1'b1;
                sync_errcnt  <= errcnt;
                sync_time_us <= timer;
                state        <= IDLE;
                correWindow  <= 1'b0;
                search_busy  <= 1'b0;
              end else if (cfg.win != '0 && timer == cfg.win - TMR_W'(1)) begin
                sync_timeout_p <= 1'b1;
                state          <= IDLE;
                correWindow    <= 1'b0;
                search_busy    <= 1'b0;
              end else if (timer != '1) begin
                // Saturate so an unlimited window never reports a wrapped time.
                timer <= timer + TMR_W'(1);
              end
            end
          end
          default: begin
            state       <= IDLE;
            correWindow <= 1'b0;
            search_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_syncsearch_ctrl.sv
`timescale 1ns/1ps
// Bench for syncsearch_ctrl: random receive words with chosen Hamming
// distances, outcome predicted by a per-evaluation scan of the error list.
module tb_syncsearch_ctrl;
  localparam int TMR_W = 16;

  logic             clk_6M = 1'b0;
  logic             rstz = 1'b0;
  logic             p_1us = 1'b0;
  logic             search_start = 1'b0;
  logic             search_abort = 1'b0;
  logic [5:0]       regi_correthreshold = '0;
  logic [TMR_W-1:0] regi_searchwindow = '0;
  logic [63:0]      syncinword = '0;
  logic [63:0]      ref_sync = '0;
  logic             correWindow, search_busy, sync_found_p, sync_timeout_p;
  logic [6:0]       sync_errcnt;
  logic [TMR_W-1:0] sync_time_us;

  int   errors = 0;
  int   checks = 0;
  int   n_found = 0;
  int   n_tmo = 0;
  logic pulse_bad = 1'b0;

  always #5 clk_6M = ~clk_6M;

  syncsearch_ctrl #(.FILL_BITS(64), .TMR_W(TMR_W)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us),
    .search_start(search_start), .search_abort(search_abort),
    .regi_correthreshold(regi_correthreshold), .regi_searchwindow(regi_searchwindow),
    .syncinword(syncinword), .ref_sync(ref_sync),
    .correWindow(correWindow), .search_busy(search_busy),
    .sync_found_p(sync_found_p), .sync_timeout_p(sync_timeout_p),
    .sync_errcnt(sync_errcnt), .sync_time_us(sync_time_us)
  );

  // Word at exactly n bits from the reference.
  function automatic logic [63:0] wwe(input int n);
    logic [63:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(63, 0)] = 1'b1;
    return ref_sync ^ m;
  endfunction

  // One clock: apply inputs, step, observe 1 ns after the edge.
  task automatic cyc(input logic p, input logic [63:0] w);
    p_1us = p;
    if (p) syncinword = w;
    @(posedge clk_6M); #1;
    p_1us = 1'b0;
    if (sync_found_p) n_found++;
    if (sync_timeout_p) n_tmo++;
    if ((sync_found_p || sync_timeout_p) && search_busy) pulse_bad = 1'b1;
  endtask

  task automatic fill(input int n);
    repeat (n) begin
      cyc(1'b1, wwe($urandom_range(64, 0)));
      repeat (5) cyc(1'b0, '0);
    end
  endtask

  task automatic start(input int thr, input int win, input logic p);
    regi_correthreshold = 6'(thr);
    regi_searchwindow = TMR_W'(win);
    search_start = 1'b1;
    n_found = 0; n_tmo = 0; pulse_bad = 1'b0;
    cyc(p, wwe($urandom_range(64, 0)));
    search_start = 1'b0;
    // Scramble config after the start; it must have no effect.
    regi_correthreshold = 6'($urandom);
    regi_searchwindow = TMR_W'($urandom);
  endtask

  // Drive one tick per listed error count (first = 64th tick after start).
  task automatic run_evals(input int errs[$], output int end_e, output logic cw0);
    end_e = -1; cw0 = 1'b0;
    for (int e = 0; e < errs.size(); e++) begin
      cyc(1'b1, wwe(errs[e]));
      if (e == 0) cw0 = correWindow;
      repeat (5) cyc(1'b0, '0);
      if (!search_busy) begin end_e = e; break; end
    end
  endtask

  // Reference: first eval within threshold is a hit (time = eval index);
  // otherwise the window expires on eval win-1; win 0 never expires.
  task automatic model(input int thr, input int win, input int errs[$],
                       output int kind, output int me, output int merr);
    kind = 0; me = -1; merr = 0;
    for (int e = 0; e < errs.size(); e++) begin
      if (errs[e] <= thr) begin kind = 1; me = e; merr = errs[e]; return; end
      if (win != 0 && e == win - 1) begin kind = 2; me = e; return; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_6M);
    #1;
    checks++; if ({correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us}); end
    rstz = 1'b1;
    repeat (3) cyc(1'b1, wwe(10));
    checks++; if ({correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", {correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us}); end
  endtask

  task automatic test_basic_hit();
    int errs[$]; int end_e, kind, me, merr; logic cw0;
    for (int i = 0; i < 9; i++) errs.push_back($urandom_range(64, 1));
    errs.push_back(0);
    model(0, 100, errs, kind, me, merr);
    start(0, 100, 1'b1);   // tick in the start cycle must not count
    checks++; if (search_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", search_busy); end
    fill(63);
    checks++; if (correWindow !== 1'b0) begin errors++; $display("FAIL basic_cw_fill: got %b want 0", correWindow); end
    run_evals(errs, end_e, cw0);
    checks++; if (cw0 !== 1'b1) begin errors++; $display("FAIL basic_cw_tick64: got %b want 1", cw0); end
    checks++; if (n_found !== 1 || n_tmo !== 0) begin errors++; $display("FAIL basic_pulses: got found=%0d tmo=%0d want 1/0", n_found, n_tmo); end
    checks++; if (end_e !== me) begin errors++; $display("FAIL basic_end: got %0d want %0d", end_e, me); end
    checks++; if (sync_errcnt !== 7'(merr) || sync_time_us !== TMR_W'(me)) begin
      errors++; $display("FAIL basic_result: got err=%0d t=%0d want %0d/%0d", sync_errcnt, sync_time_us, merr, me); end
    checks++; if (pulse_bad !== 1'b0 || search_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got bad=%b busy=%b want 0/0", pulse_bad, search_busy); end
  endtask

  task automatic test_threshold();
    int errs[$]; int end_e, kind, me, merr; logic cw0;
    errs = '{$urandom_range(64, 4), $urandom_range(64, 4), 4, 3};
    model(3, 0, errs, kind, me, merr);
    start(3, 0, 1'b0);
    fill(63);
    run_evals(errs, end_e, cw0);
    checks++; if (n_found !== 1 || end_e !== me) begin errors++; $display("FAIL thr_hit: got found=%0d e=%0d want 1/%0d", n_found, end_e, me); end
    checks++; if (sync_errcnt !== 7'd3 || sync_time_us !== TMR_W'(me)) begin
      errors++; $display("FAIL thr_result: got err=%0d t=%0d want 3/%0d", sync_errcnt, sync_time_us, me); end
  endtask

  task automatic test_timeout();
    int errs[$]; int end_e, kind, me, merr, thr; logic cw0;
    thr = $urandom_range(10, 0);
    for (int i = 0; i < 7; i++) errs.push_back($urandom_range(64, thr + 1));
    model(thr, 5, errs, kind, me, merr);
    start(thr, 5, 1'b0);
    fill(63);
    run_evals(errs, end_e, cw0);
    checks++; if (n_tmo !== 1 || n_found !== 0) begin errors++; $display("FAIL tmo_pulses: got tmo=%0d found=%0d want 1/0", n_tmo, n_found); end
    checks++; if (end_e !== me) begin errors++; $display("FAIL tmo_evals: got %0d want %0d", end_e, me); end
    checks++; if (correWindow !== 1'b0 || pulse_bad !== 1'b0) begin errors++; $display("FAIL tmo_cw: got cw=%b bad=%b want 0/0", correWindow, pulse_bad); end
    checks++; if (sync_errcnt !== 7'd0 || sync_time_us !== '0) begin errors++; $display("FAIL tmo_held: got %0d/%0d want 0/0", sync_errcnt, sync_time_us); end
  endtask

  task automatic test_hit_at_expiry();
    int errs[$]; int end_e, kind, me, merr; logic cw0;
    for (int i = 0; i < 4; i++) errs.push_back($urandom_range(64, 3));
    errs.push_back($urandom_range(2, 0));
    model(2, 5, errs, kind, me, merr);
    start(2, 5, 1'b0);
    fill(63);
    run_evals(errs, end_e, cw0);
    checks++; if (n_found !== 1 || n_tmo !== 0) begin errors++; $display("FAIL expiry_pulses: got found=%0d tmo=%0d want 1/0", n_found, n_tmo); end
    checks++; if (sync_time_us !== TMR_W'(4) || sync_errcnt !== 7'(merr)) begin
      errors++; $display("FAIL expiry_result: got t=%0d err=%0d want 4/%0d", sync_time_us, sync_errcnt, merr); end
  endtask

  task automatic test_abort(input int held_err, input int held_t);
    // Abort with start: start refused, held results untouched.
    search_abort = 1'b1;
    start(0, 100, 1'b0);
    search_abort = 1'b0;
    repeat (2) cyc(1'b0, '0);
    checks++; if (search_busy !== 1'b0 || sync_errcnt !== 7'(held_err) || sync_time_us !== TMR_W'(held_t)) begin
      errors++; $display("FAIL abort_with_start: got busy=%b err=%0d t=%0d want 0/%0d/%0d", search_busy, sync_errcnt, sync_time_us, held_err, held_t); end
    // Abort during FILL, then keep ticking: nothing must happen.
    start(63, 0, 1'b0);
    fill(20);
    search_abort = 1'b1; cyc(1'b0, '0); search_abort = 1'b0;
    fill(50);
    checks++; if (search_busy !== 1'b0 || correWindow !== 1'b0 || n_found !== 0 || n_tmo !== 0) begin
      errors++; $display("FAIL abort_fill: got busy=%b cw=%b found=%0d tmo=%0d want 0/0/0/0", search_busy, correWindow, n_found, n_tmo); end
    // Abort on the very eval that would hit.
    start(63, 0, 1'b0);
    fill(63);
    cyc(1'b1, wwe(0));
    search_abort = 1'b1; cyc(1'b0, '0); search_abort = 1'b0;
    repeat (4) cyc(1'b0, '0);
    checks++; if (n_found !== 0 || search_busy !== 1'b0 || correWindow !== 1'b0 || sync_errcnt !== 7'd0 || sync_time_us !== '0) begin
      errors++; $display("FAIL abort_search: got found=%0d busy=%b cw=%b err=%0d t=%0d want 0/0/0/0/0", n_found, search_busy, correWindow, sync_errcnt, sync_time_us); end
  endtask

  task automatic test_start_while_busy();
    int errs[$]; int end_e, kind, me, merr; logic cw0;
    errs = '{$urandom_range(64, 1), $urandom_range(64, 1), $urandom_range(64, 1), 0};
    model(0, 100, errs, kind, me, merr);
    start(0, 100, 1'b0);
    fill(10);
    regi_correthreshold = 6'd63; regi_searchwindow = TMR_W'(1);
    search_start = 1'b1; cyc(1'b0, '0); search_start = 1'b0;
    fill(53);
    run_evals(errs, end_e, cw0);
    checks++; if (cw0 !== 1'b1 || end_e !== me || n_found !== 1 || n_tmo !== 0) begin
      errors++; $display("FAIL busy_start: got cw=%b e=%0d found=%0d tmo=%0d want 1/%0d/1/0", cw0, end_e, n_found, n_tmo, me); end
  endtask

  task automatic test_unlimited();
    int errs[$]; int end_e, kind, me, merr; logic cw0;
    for (int i = 0; i < 999; i++) errs.push_back($urandom_range(64, 6));
    errs.push_back($urandom_range(5, 0));
    model(5, 0, errs, kind, me, merr);
    start(5, 0, 1'b0);
    fill(63);
    run_evals(errs, end_e, cw0);
    checks++; if (n_tmo !== 0 || n_found !== 1) begin errors++; $display("FAIL unlim_pulses: got tmo=%0d found=%0d want 0/1", n_tmo, n_found); end
    checks++; if (sync_time_us !== TMR_W'(999) || sync_errcnt !== 7'(merr)) begin
      errors++; $display("FAIL unlim_result: got t=%0d err=%0d want 999/%0d", sync_time_us, sync_errcnt, merr); end
  endtask

  task automatic test_rst_mid_search();
    start(5, 0, 1'b0);
    fill(63);
    repeat (3) begin cyc(1'b1, wwe($urandom_range(64, 6))); repeat (5) cyc(1'b0, '0); end
    checks++; if (correWindow !== 1'b1 || search_busy !== 1'b1) begin errors++; $display("FAIL rst_pre: got cw=%b busy=%b want 1/1", correWindow, search_busy); end
    #2 rstz = 1'b0;
    #1;
    checks++; if ({correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us} !== '0) begin
      errors++; $display("FAIL rst_async: got %h want 0", {correWindow, search_busy, sync_found_p, sync_timeout_p, sync_errcnt, sync_time_us}); end
    @(posedge clk_6M); #1 rstz = 1'b1;
    repeat (12) cyc(1'b1, wwe(0));
    checks++; if (search_busy !== 1'b0 || n_found !== 0) begin errors++; $display("FAIL rst_after: got busy=%b found=%0d want 0/0", search_busy, n_found); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int errs[$]; int end_e, kind, me, merr, thr, win, len; logic cw0;
      thr = $urandom_range(20, 0);
      win = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(12, 1);
      len = (win != 0) ? win + 2 : 16;
      for (int i = 0; i < len; i++)
        errs.push_back(($urandom_range(9, 0) == 0) ? $urandom_range(thr, 0) : $urandom_range(64, thr + 1));
      model(thr, win, errs, kind, me, merr);
      start(thr, win, 1'($urandom_range(1, 0)));
      fill(63);
      run_evals(errs, end_e, cw0);
      if (kind == 0) begin search_abort = 1'b1; cyc(1'b0, '0); search_abort = 1'b0; cyc(1'b0, '0); end
      checks++; if (n_found !== int'(kind == 1) || n_tmo !== int'(kind == 2) || end_e !== me) begin
        errors++; $display("FAIL rand%0d_outcome: got found=%0d tmo=%0d e=%0d want kind=%0d e=%0d", it, n_found, n_tmo, end_e, kind, me); end
      checks++; if (sync_errcnt !== 7'(merr) || sync_time_us !== TMR_W'(kind == 1 ? me : 0)) begin
        errors++; $display("FAIL rand%0d_result: got err=%0d t=%0d want %0d/%0d", it, sync_errcnt, sync_time_us, merr, (kind == 1 ? me : 0)); end
    end
  endtask

  initial begin
    ref_sync = {$urandom, $urandom};
    test_reset();
    test_basic_hit();
    test_threshold();
    test_timeout();
    test_hit_at_expiry();
    test_abort(int'(sync_errcnt), 4);
    test_start_while_busy();
    test_unlimited();
    test_rst_mid_search();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
